rooth_test_monitor: RTL and testbench



---
 rtl/rooth_test_monitor_if.sv | 23 ++
 rtl/rooth_test_monitor.sv | 232 +++++++++++++++++++++++
 tb/tb_rooth_test_monitor.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rooth_test_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : rooth_test_monitor_if
// Description : Register-file writeback snoop bus between the rooth core
//               (master) and the end-of-test monitor (slave).
// Signals     : wb_en    - register-file write enable
//               wb_addr  - register-file write index (5 bits)
//               wb_data  - register-file write data (CPU_WIDTH bits)
//               retire   - one instruction retired this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface rooth_test_monitor_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 wb_en;
  logic [4:0]           wb_addr;
  logic [CPU_WIDTH-1:0] wb_data;
  logic                 retire;

  modport master (output wb_en, wb_addr, wb_data, retire);
  modport slave  (input  wb_en, wb_addr, wb_data, retire);
endinterface
`default_nettype wire

// File: rtl/rooth_test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : rooth_test_monitor
// Description : End-of-test monitor for the rooth core. Snoops register-file
//               writeback, shadows the test-number / done / pass registers and
//               decides PASS, FAIL or TIMEOUT in hardware. Results are sticky
//               until rst or i_clear.
// Ports       : clk            - system clock
//               rst            - asynchronous active-high reset
//               i_clear        - synchronous restart into RUN
//               wb             - writeback snoop bus (slave modport)
//               o_done         - test ended (pass, fail or timeout)
//               o_pass         - pass register held 1 at sample time
//               o_fail         - pass register did not hold 1 at sample time
//               o_timeout      - watchdog expired before done
//               o_fail_testnum - test-number shadow frozen at decision
//               o_cycle_cnt    - cycles spent in RUN/SETTLE, saturating
//               o_retire_cnt   - retires seen in RUN/SETTLE, saturating
// Options     : ROOTH_TEST_MON_TIMEOUT_EN - build in the watchdog / TMO state
// Revision    : 1.0 - initial release
// ============================================================================
module rooth_test_monitor #(
  parameter int CPU_WIDTH      = 32,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int TNUM_REG       = 3,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire                      clk,
  input  wire                      rst,
  input  wire                      i_clear,
  rooth_test_monitor_if.slave      wb,
  output logic                     o_done,
  output logic                     o_pass,
  output logic                     o_fail,
  output logic                     o_timeout,
  output logic [CPU_WIDTH-1:0]     o_fail_testnum,
  output logic [31:0]              o_cycle_cnt,
  output logic [31:0]              o_retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SETTLE = 3'd2,
    S_PASS   = 3'd3,
    S_FAIL   = 3'd4
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
    , S_TMO  = 3'd5
`endif
  } state_t;

  localparam logic [4:0]           c_done_addr   = 5'(DONE_REG);
  localparam logic [4:0]           c_pass_addr   = 5'(PASS_REG);
  localparam logic [4:0]           c_tnum_addr   = 5'(TNUM_REG);
  localparam logic [3:0]           c_settle_init = 4'(SETTLE_CYCLES);
  localparam logic [CPU_WIDTH-1:0] c_one         = CPU_WIDTH'(1);
  localparam logic [31:0]          c_cnt_max     = 32'hFFFF_FFFF;
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
  // Firing one count early makes timeout rise on the same edge at which
  // cycle_cnt reaches TIMEOUT_CYCLES.
  localparam logic [31:0]          c_tmo_last    = 32'(TIMEOUT_CYCLES - 1);
`endif

  // Elaboration-time range check on the timing parameters.
  generate
    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
      $error("rooth_test_monitor: SETTLE_CYCLES must be 1..15 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_settle, w_settle_nxt;
  logic [CPU_WIDTH-1:0] r_tnum, r_pass_q, r_done_q;
  logic [CPU_WIDTH-1:0] w_tnum_nxt, w_pass_q_nxt, w_done_q_nxt;
  logic [31:0]          r_cycle_cnt, r_retire_cnt;
  logic                 r_done, r_pass, r_fail;
  logic                 w_done_nxt, w_pass_nxt, w_fail_nxt;
  logic [CPU_WIDTH-1:0] r_ftn, w_ftn_nxt;
  logic                 w_wr, w_tnum_wr, w_pass_wr, w_done_wr, w_done_trig;
  logic                 w_active, w_track;
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
  logic                 r_timeout, w_timeout_nxt;
`endif

  // Writes to x0 never reach the shadows.
  assign w_wr        = wb.wb_en && (wb.wb_addr != 5'd0);
  assign w_tnum_wr   = w_wr && (wb.wb_addr == c_tnum_addr);
  assign w_pass_wr   = w_wr && (wb.wb_addr == c_pass_addr);
  assign w_done_wr   = w_wr && (wb.wb_addr == c_done_addr);
  assign w_done_trig = w_done_wr && (wb.wb_data == c_one);

  // Shadow values including this cycle's write, so a pass-register write in
  // the last settle cycle is seen by the decision.
  assign w_tnum_nxt   = w_tnum_wr ? wb.wb_data : r_tnum;
  assign w_pass_q_nxt = w_pass_wr ? wb.wb_data : r_pass_q;
  assign w_done_q_nxt = w_done_wr ? wb.wb_data : r_done_q;

  assign w_active = (r_state == S_RUN) || (r_state == S_SETTLE);
  // Shadows follow traffic until a verdict is reached, then freeze.
  assign w_track  = (r_state == S_IDLE) || w_active;

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_done_nxt   = r_done;
    w_pass_nxt   = r_pass;
    w_fail_nxt   = r_fail;
    w_ftn_nxt    = r_ftn;
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
    w_timeout_nxt = r_timeout;
`endif
    case (r_state)
      S_IDLE: w_state_nxt = S_RUN;
      S_RUN: begin
        // A done write beats a watchdog expiry in the same cycle.
        if (w_done_trig) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = c_settle_init;
        end
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
        else if (r_cycle_cnt == c_tmo_last) begin
          w_state_nxt   = S_TMO;
          w_done_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
          w_ftn_nxt     = r_tnum;
        end
`endif
      end
      S_SETTLE: begin
        if (r_settle <= 4'd1) begin
          w_settle_nxt = 4'd0;
          w_done_nxt   = 1'b1;
          if (w_pass_q_nxt == c_one) begin
            w_state_nxt = S_PASS;
            w_pass_nxt  = 1'b1;
            w_ftn_nxt   = '0;
          end else begin
            w_state_nxt = S_FAIL;
            w_fail_nxt  = 1'b1;
            w_ftn_nxt   = r_tnum;
          end
        end else begin
          w_settle_nxt = r_settle - 4'd1;
        end
      end
      default: ; // verdict states hold until rst or clear
    endcase
    // Restart overrides any transition and lands directly in RUN.
    if (i_clear) begin
      w_state_nxt  = S_RUN;
      w_settle_nxt = 4'd0;
      w_done_nxt   = 1'b0;
      w_pass_nxt   = 1'b0;
      w_fail_nxt   = 1'b0;
      w_ftn_nxt    = '0;
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
      w_timeout_nxt = 1'b0;
`endif
    end
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_settle <= 4'd0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_ftn    <= '0;
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_done   <= w_done_nxt;
      r_pass   <= w_pass_nxt;
      r_fail   <= w_fail_nxt;
      r_ftn    <= w_ftn_nxt;
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  // Shadows and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tnum       <= '0;
      r_pass_q     <= '0;
      r_done_q     <= '0;
      r_cycle_cnt  <= 32'd0;
      r_retire_cnt <= 32'd0;
    end else if (i_clear) begin
      r_tnum       <= '0;
      r_pass_q     <= '0;
      r_done_q     <= '0;
      r_cycle_cnt  <= 32'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      if (w_track) begin
        r_tnum   <= w_tnum_nxt;
        r_pass_q <= w_pass_q_nxt;
        r_done_q <= w_done_q_nxt;
      end
      if (w_active && (r_cycle_cnt != c_cnt_max)) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (w_active && wb.retire && (r_retire_cnt != c_cnt_max)) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  assign o_done         = r_done;
  assign o_pass         = r_pass;
  assign o_fail         = r_fail;
  assign o_fail_testnum = r_ftn;
  assign o_cycle_cnt    = r_cycle_cnt;
  assign o_retire_cnt   = r_retire_cnt;
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
  assign o_timeout      = r_timeout;
`else
  assign o_timeout      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rooth_test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_rooth_test_monitor
// Description : Self-checking bench for rooth_test_monitor. Directed scenarios
//               plus randomized writeback traces, each scored against a
//               trace-level reference model of the end-of-test rules.
// Options     : ROOTH_TEST_MON_TIMEOUT_EN selects watchdog expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rooth_test_monitor;
  localparam int CPU_WIDTH      = 32;
  localparam int DONE_REG       = 26;
  localparam int PASS_REG       = 27;
  localparam int TNUM_REG       = 3;
  localparam int SETTLE_CYCLES  = 1;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int MAXLEN         = 256;
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear;
  logic                 o_done, o_pass, o_fail, o_timeout;
  logic [CPU_WIDTH-1:0] o_fail_testnum;
  logic [31:0]          o_cycle_cnt, o_retire_cnt;

  rooth_test_monitor_if #(.CPU_WIDTH(CPU_WIDTH)) wb_if ();

  rooth_test_monitor #(
    .CPU_WIDTH      (CPU_WIDTH),
    .DONE_REG       (DONE_REG),
    .PASS_REG       (PASS_REG),
    .TNUM_REG       (TNUM_REG),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (clear),
    .wb             (wb_if),
    .o_done         (o_done),
    .o_pass         (o_pass),
    .o_fail         (o_fail),
    .o_timeout      (o_timeout),
    .o_fail_testnum (o_fail_testnum),
    .o_cycle_cnt    (o_cycle_cnt),
    .o_retire_cnt   (o_retire_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus trace: one entry per RUN cycle, index 0 = first cycle after
  // entering RUN.
  logic        s_en   [MAXLEN];
  logic [4:0]  s_addr [MAXLEN];
  logic [31:0] s_data [MAXLEN];
  logic        s_ret  [MAXLEN];

  // Model results: decision index (-1 = still running), verdict kind
  // (0 running, 1 pass, 2 fail, 3 timeout), frozen test number, counters.
  int          e_dec;
  int          e_kind;
  logic [31:0] e_ftn;
  logic [31:0] e_cycles;
  logic [31:0] e_retires;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [4:0] a, input logic [31:0] d,
                      input logic ret, input logic clr);
    wb_if.wb_en   = en;
    wb_if.wb_addr = a;
    wb_if.wb_data = d;
    wb_if.retire  = ret;
    clear         = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic seq_clear(input int len);
    for (int i = 0; i < len; i++) begin
      s_en[i] = 1'b0; s_addr[i] = 5'd0; s_data[i] = 32'd0; s_ret[i] = 1'b0;
    end
  endtask

  task automatic seq_wr(input int i, input logic [4:0] a, input logic [31:0] d);
    s_en[i] = 1'b1; s_addr[i] = a; s_data[i] = d;
  endtask

  // Trace-level reference: the first x26==1 write starts the settle window;
  // the verdict uses the newest x27 value seen through the last settle cycle
  // and the x3 value held before the decision cycle. Without a done write the
  // watchdog (if built) ends the test in the cycle cycle_cnt reaches the limit.
  task automatic model(input int len);
    int          trig;
    logic [31:0] tn, pv;
    logic        wr;
    int          last;
    trig = -1; tn = 32'd0; pv = 32'd0;
    e_dec = -1; e_kind = 0; e_ftn = 32'd0;
    for (int i = 0; i < len; i++) begin
      if (e_dec < 0) begin
        wr = s_en[i] && (s_addr[i] != 5'd0);
        if (trig < 0 && wr && s_addr[i] == 5'(DONE_REG) && s_data[i] == 32'd1) trig = i;
        if (wr && s_addr[i] == 5'(PASS_REG)) pv = s_data[i];
        if (trig >= 0 && i == trig + SETTLE_CYCLES) begin
          e_dec  = i;
          e_kind = (pv == 32'd1) ? 1 : 2;
          e_ftn  = (pv == 32'd1) ? 32'd0 : tn;
        end else if (trig < 0 && TMO_EN && i == TIMEOUT_CYCLES - 1) begin
          e_dec  = i;
          e_kind = 3;
          e_ftn  = tn;
        end
        if (wr && s_addr[i] == 5'(TNUM_REG)) tn = s_data[i];
      end
    end
    last      = (e_dec >= 0) ? e_dec + 1 : len;
    e_cycles  = 32'(last);
    e_retires = 32'd0;
    for (int i = 0; i < last; i++) e_retires += 32'(s_ret[i]);
  endtask

  task automatic run_seq(input string tag, input int len);
    model(len);
    for (int i = 0; i < len; i++) begin
      step(s_en[i], s_addr[i], s_data[i], s_ret[i], 1'b0);
      check({tag, "/done"}, 32'(o_done), 32'(e_dec >= 0 && i >= e_dec));
    end
    check({tag, "/pass"},    32'(o_pass),    32'(e_kind == 1));
    check({tag, "/fail"},    32'(o_fail),    32'(e_kind == 2));
    check({tag, "/timeout"}, 32'(o_timeout), 32'(e_kind == 3));
    check({tag, "/ftn"},     o_fail_testnum, e_ftn);
    check({tag, "/cycles"},  o_cycle_cnt,    e_cycles);
    check({tag, "/retires"}, o_retire_cnt,   e_retires);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int          len;
    int          pick;
    logic [4:0]  a;
    logic [31:0] d;

    rst = 1'b1; clear = 1'b0;
    wb_if.wb_en = 1'b0; wb_if.wb_addr = 5'd0; wb_if.wb_data = 32'd0; wb_if.retire = 1'b0;
    repeat (2) @(negedge clk);
    check("rst/done",    32'(o_done),    32'd0);
    check("rst/pass",    32'(o_pass),    32'd0);
    check("rst/fail",    32'(o_fail),    32'd0);
    check("rst/timeout", 32'(o_timeout), 32'd0);
    check("rst/ftn",     o_fail_testnum, 32'd0);
    check("rst/cycles",  o_cycle_cnt,    32'd0);
    check("rst/retires", o_retire_cnt,   32'd0);
    rst = 1'b0;
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0); // IDLE -> RUN

    // Pass path: x27=1 then x26=1
    seq_clear(4);
    seq_wr(0, 5'd27, 32'd1);
    seq_wr(1, 5'd26, 32'd1);
    run_seq("t1_pass", 4);
    check("t1/pass_const", 32'(o_pass), 32'd1);
    check("t1/ftn_const",  o_fail_testnum, 32'd0);

    // Clear while in PASS, then count 10 retires
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    check("clr/done",    32'(o_done),  32'd0);
    check("clr/pass",    32'(o_pass),  32'd0);
    check("clr/cycles",  o_cycle_cnt,  32'd0);
    check("clr/retires", o_retire_cnt, 32'd0);
    repeat (10) step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("clr/retire10", o_retire_cnt, 32'd10);
    check("clr/cycle10",  o_cycle_cnt,  32'd10);
    check("clr/run_done", 32'(o_done),  32'd0);

    // Fail path with frozen test number
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    seq_clear(7);
    seq_wr(0, 5'd3, 32'd5);
    seq_wr(1, 5'd27, 32'd0);
    seq_wr(2, 5'd26, 32'd1);
    seq_wr(5, 5'd3, 32'd9);
    run_seq("t2_fail", 7);
    check("t2/fail_const", 32'(o_fail), 32'd1);
    check("t2/ftn_const",  o_fail_testnum, 32'd5);

    // Asynchronous reset mid-cycle while a verdict is held
    #2 rst = 1'b1;
    #1;
    check("arst/done",    32'(o_done),  32'd0);
    check("arst/fail",    32'(o_fail),  32'd0);
    check("arst/ftn",     o_fail_testnum, 32'd0);
    check("arst/cycles",  o_cycle_cnt,  32'd0);
    check("arst/retires", o_retire_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Pass-register write inside the settle window counts
    seq_clear(4);
    seq_wr(0, 5'd26, 32'd1);
    seq_wr(1, 5'd27, 32'd1);
    run_seq("t3_settle", 4);
    check("t3/pass_const", 32'(o_pass), 32'd1);

    // Non-1 done write and x0 writes do not end the test
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    seq_clear(7);
    seq_wr(0, 5'd26, 32'd2);
    seq_wr(1, 5'd0, 32'd1);
    seq_wr(2, 5'd0, 32'd1);
    seq_wr(4, 5'd26, 32'd1);
    run_seq("t4_x0", 7);

    // Clear wins over a done write in the same cycle
    step(1'b1, 5'd26, 32'd1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("clrpri/done",   32'(o_done), 32'd0);
    check("clrpri/cycles", o_cycle_cnt, 32'd3);

    // Watchdog
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    seq_clear(200);
    seq_wr(0, 5'd3, 32'd7);
    for (int i = 0; i < 200; i++) s_ret[i] = 1'($urandom_range(0, 1));
    run_seq("t5_wdog", 200);
`ifdef ROOTH_TEST_MON_TIMEOUT_EN
    check("t5/timeout_const", 32'(o_timeout), 32'd1);
    check("t5/cycles_const",  o_cycle_cnt,    32'd100);
    check("t5/ftn_const",     o_fail_testnum, 32'd7);
`else
    check("t5/done_const",    32'(o_done),    32'd0);
    check("t5/cycles_const",  o_cycle_cnt,    32'd200);
    check("t5/timeout_const", 32'(o_timeout), 32'd0);
`endif

    // Randomized writeback traces
    for (int r = 0; r < 20; r++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      len = 30 + int'($urandom_range(0, 20));
      seq_clear(len);
      for (int i = 0; i < len; i++) begin
        pick = int'($urandom_range(0, 9));
        case (pick)
          0:       a = 5'd0;
          1, 2:    a = 5'd3;
          3, 4:    a = 5'd27;
          5:       a = 5'd26;
          default: a = 5'($urandom);
        endcase
        pick = int'($urandom_range(0, 4));
        case (pick)
          0:       d = 32'd0;
          1, 2:    d = 32'd1;
          3:       d = 32'd2;
          default: d = $urandom;
        endcase
        s_en[i]   = 1'($urandom_range(0, 1));
        s_addr[i] = a;
        s_data[i] = d;
        s_ret[i]  = 1'($urandom_range(0, 1));
      end
      run_seq($sformatf("rnd%0d", r), len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
